bin2bcd_seq: RTL and testbench

//  Parametrised sequential binary-to-BCD converter for the display path; generalises the fixed 4-bit tens/ones decoder
//  to any input width and digit count. Iterative shift-add-3 (double-dabble), one bit per clock.

---
 rtl/bin2bcd_pkg.sv | 18 +
 rtl/bin2bcd_seq_adj.sv | 13 +
 rtl/bin2bcd_seq.sv | 115 +++++++++++
 tb/tb_bin2bcd_seq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Holds the FSM state enum, the blank-digit code and the digit-count check.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam logic [3:0] BLANK = 4'hF;

  // Decimal digits of 2**bin_w-1 == floor(bin_w*log10(2))+1.
  function automatic int min_digits(input int bin_w);
    return (bin_w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_adj.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more.
// Purely combinational; the top instantiates one per BCD digit.
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = d;
    if (d >= 4'd5) q = d + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter, one input bit per clock, valid/ready.
// Define BIN2BCD_LZ_BLANK_EN to blank leading-zero digits to 4'hF.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd
);

  localparam int AW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  if (BIN_W < 1) begin : g_bad_w
    $error("bin2bcd_seq: BIN_W must be >= 1");
  end
  if (DIGITS < min_digits(BIN_W)) begin : g_bad_d
    $error("bin2bcd_seq: DIGITS too small for BIN_W");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [AW-1:0]    out_q, out_d;
  logic [AW-1:0]    adj;
  logic [AW-1:0]    acc_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (acc_q[4*g +: 4]),
      .q (adj[4*g +: 4])
    );
  end

  assign acc_shift = {adj[AW-2:0], bin_q[BIN_W-1]};

`ifdef BIN2BCD_LZ_BLANK_EN
  function automatic logic [AW-1:0] fmt(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    logic          seen;
    r    = v;
    seen = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (!seen && v[4*i +: 4] == 4'd0) r[4*i +: 4] = BLANK;
      else seen = 1'b1;
    end
    return r;
  endfunction
`else
  function automatic logic [AW-1:0] fmt(input logic [AW-1:0] v);
    return v;
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d   = in_bin;
          acc_d   = '0;
          cnt_d   = CW'(BIN_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = acc_shift;
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          out_d   = fmt(acc_shift);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_bcd   = out_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq (BIN_W=8, DIGITS=3).
// Expected digits come from a divide-by-10 model held in a scoreboard queue.
module tb_bin2bcd_seq;

  localparam int BIN_W  = 8;
  localparam int DIGITS = 3;
  localparam int AW     = 4 * DIGITS;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [BIN_W-1:0] in_bin = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [AW-1:0]    out_bcd;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  logic [AW-1:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd)
  );

  function automatic logic [AW-1:0] ref_bcd(input int v);
    logic [AW-1:0] r;
    int            x;
    bit            lead;
    r    = '0;
    x    = v;
    lead = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef BIN2BCD_LZ_BLANK_EN
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead && r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
`endif
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v, output bit ok);
    int t = 0;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    ok       = in_ready;
    in_valid = 1'b1;
    in_bin   = BIN_W'(v);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    rst       = 1'b1;
    step();
    step();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bcd !== '0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b out_bcd=%h want 1 0 000",
               in_ready, out_valid, out_bcd);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b0;
    step();
  endtask

  task automatic test_values();
    int            vals[8] = '{0, 9, 255, 100, 199, 7, 40, 205};
`ifdef BIN2BCD_LZ_BLANK_EN
    logic [AW-1:0] lit[8] = '{12'hFF0, 12'hFF9, 12'h255, 12'h100,
                              12'h199, 12'hFF7, 12'hF40, 12'h205};
`else
    logic [AW-1:0] lit[8] = '{12'h000, 12'h009, 12'h255, 12'h100,
                              12'h199, 12'h007, 12'h040, 12'h205};
`endif
    logic [AW-1:0] exp;
    bit            ok;
    int            lat;
    for (int i = 0; i < 8; i++) begin
      send(vals[i], ok);
      sb.push_back(ref_bcd(vals[i]));
      wait_out(lat);
      n_checks++;
      if (!ok || lat != BIN_W) begin
        n_fail++;
        $display("FAIL latency in=%0d: got %0d edges (ready_ok=%b) want %0d",
                 vals[i], lat, ok, BIN_W);
      end
      exp = sb.pop_front();
      n_checks++;
      if (out_bcd !== exp) begin
        n_fail++;
        $display("FAIL model in=%0d: out_bcd=%h want %h", vals[i], out_bcd, exp);
      end
      n_checks++;
      if (out_bcd !== lit[i]) begin
        n_fail++;
        $display("FAIL literal in=%0d: out_bcd=%h want %h", vals[i], out_bcd, lit[i]);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL handshake in=%0d: out_valid=%b in_ready=%b want 0 1",
                 vals[i], out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] exp;
    bit            ok;
    bit            bad;
    int            lat;
    send(123, ok);
    sb.push_back(ref_bcd(123));
    wait_out(lat);
    exp = sb.pop_front();
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      in_bin   = BIN_W'($urandom_range(0, 255));
      step();
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_bcd !== exp) begin
        n_fail++;
        $display("FAIL hold cyc%0d: v=%b r=%b bcd=%h want 1 0 %h",
                 i, out_valid, in_ready, out_bcd, exp);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL ignored_pulses: out_valid=1 want 0 (value captured in DONE)");
    end
  endtask

  task automatic test_rst_mid_shift();
    bit            ok;
    bit            bad;
    int            lat;
    logic [AW-1:0] exp;
    send(173, ok);
    sb.push_back(ref_bcd(173));
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(sb.pop_back());
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bcd !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: in_ready=%b out_valid=%b out_bcd=%h want 1 0 000",
               in_ready, out_valid, out_bcd);
    end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid !== 1'b0 || out_bcd === ref_bcd(173)) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL rst_abandon: out_valid=%b out_bcd=%h want 0 and no 173",
               out_valid, out_bcd);
    end
    send(42, ok);
    sb.push_back(ref_bcd(42));
    wait_out(lat);
    exp = sb.pop_front();
    n_checks++;
    if (out_bcd !== exp || lat != BIN_W) begin
      n_fail++;
      $display("FAIL after_rst: out_bcd=%h lat=%0d want %h %0d", out_bcd, lat, exp, BIN_W);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] exp;
    bit            ok;
    int            lat;
    int            prev;
    int            errs;
    int            gap_errs;
    errs      = 0;
    gap_errs  = 0;
    prev      = 0;
    out_ready = 1'b1;
    for (int v = 0; v < 256; v++) begin
      send(v, ok);
      sb.push_back(ref_bcd(v));
      if (v > 0 && (cyc - prev) != BIN_W + 2) gap_errs++;
      prev = cyc;
      wait_out(lat);
      exp = sb.pop_front();
      n_checks++;
      if (out_bcd !== exp || !out_valid) begin
        n_fail++;
        errs++;
        if (errs < 10)
          $display("FAIL exhaustive in=%0d: out_bcd=%h valid=%b want %h 1",
                   v, out_bcd, out_valid, exp);
      end
      step();
    end
    out_ready = 1'b0;
    n_checks++;
    if (gap_errs != 0) begin
      n_fail++;
      $display("FAIL throughput: %0d accept gaps differ from %0d cycles", gap_errs, BIN_W + 2);
    end
  endtask

  initial begin
    test_reset();
    test_values();
    test_backpressure();
    test_rst_mid_shift();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
